// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared types for the push-button front end:
//   event_mode_t     - which accepted transitions produce a button_event pulse
//   debounce_state_t - per-channel debounce FSM states
// Also holds a small helper that decides whether a transition is reported.
// -----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        EVENT_PRESS   = 2'd0,
        EVENT_RELEASE = 2'd1,
        EVENT_BOTH    = 2'd2
    } event_mode_t;

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_PENDING   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_PENDING = 2'd3
    } debounce_state_t;

    // True when the given mode reports an accepted press (is_press=1) or release (is_press=0)
    function automatic logic event_enabled(input event_mode_t mode, input logic is_press);
        logic en;
        case (mode)
            EVENT_PRESS:   en = is_press;
            EVENT_RELEASE: en = ~is_press;
            EVENT_BOTH:    en = 1'b1;
            default:       en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One button channel: synchroniser chain, counter-based debounce FSM,
// registered level / event outputs and an optional long-press detector.
// Ports:
//   clock        in  system clock
//   reset_n      in  synchronous active-low reset
//   button_n     in  raw inverting button (0 = pressed), asynchronous
//   button_state out debounced level, 1 = pressed
//   button_event out one-cycle pulse on accepted transition selected by EVENT_MODE
//   button_long  out one-cycle pulse once a press has been held LONG_PRESS_CYCLES
// -----------------------------------------------------------------------------
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter event_mode_t EVENT_MODE        = EVENT_PRESS,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button_n,
    output logic button_state,
    output logic button_event,
    output logic button_long
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   pressed_s;
    debounce_state_t        state_q;
    debounce_state_t        state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   accept_press_s;
    logic                   accept_release_s;
    logic                   state_out_q;
    logic                   state_out_d;
    logic                   event_q;
    logic                   event_d;

    // Synchroniser shift, debounce FSM next state, and registered output values
    always_comb begin
        sync_d           = {sync_q[SYNC_STAGES-2:0], button_n};
        pressed_s        = ~sync_q[SYNC_STAGES-1];
        state_d          = state_q;
        cnt_d            = cnt_q;
        accept_press_s   = 1'b0;
        accept_release_s = 1'b0;
        case (state_q)
            RELEASED: begin
                if (pressed_s) begin
                    state_d = PRESS_PENDING;
                    cnt_d   = '0;
                end else begin
                    state_d = RELEASED;
                end
            end
            PRESS_PENDING: begin
                if (!pressed_s) begin
                    // bounce back before the level was stable long enough
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = PRESSED;
                    accept_press_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!pressed_s) begin
                    state_d = RELEASE_PENDING;
                    cnt_d   = '0;
                end else begin
                    state_d = PRESSED;
                end
            end
            RELEASE_PENDING: begin
                if (pressed_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d          = RELEASED;
                    accept_release_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
        // Outputs are computed from the next state so they line up with the transition edge
        state_out_d = (state_d == PRESSED) || (state_d == RELEASE_PENDING);
        event_d     = (accept_press_s   && event_enabled(EVENT_MODE, 1'b1)) ||
                      (accept_release_s && event_enabled(EVENT_MODE, 1'b0));
    end

    // Sync chain, FSM and output registers with synchronous reset to "released"
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q      <= '1;
            state_q     <= RELEASED;
            cnt_q       <= '0;
            state_out_q <= 1'b0;
            event_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            state_out_q <= state_out_d;
            event_q     <= event_d;
        end
    end

    assign button_state = state_out_q;
    assign button_event = event_q;

    if (LONG_PRESS_CYCLES == 0) begin : g_no_long
        assign button_long = 1'b0;
    end else begin : g_long
        localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
        localparam logic [LW-1:0] LMAX = LW'(LONG_PRESS_CYCLES);

        logic [LW-1:0] lcnt_q;
        logic [LW-1:0] lcnt_d;
        logic          long_q;
        logic          long_d;

        // Hold-time counter: restarts on each accepted press, saturates so only one pulse fires
        always_comb begin
            lcnt_d = lcnt_q;
            long_d = 1'b0;
            if (accept_press_s) begin
                lcnt_d = '0;
            end else if ((state_q == PRESSED) && (lcnt_q != LMAX)) begin
                lcnt_d = lcnt_q + LW'(1);
                long_d = (lcnt_q == LMAX - LW'(1));
            end else begin
                lcnt_d = lcnt_q;
            end
        end

        // Long-press counter and pulse register
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                lcnt_q <= '0;
                long_q <= 1'b0;
            end else begin
                lcnt_q <= lcnt_d;
                long_q <= long_d;
            end
        end

        assign button_long = long_q;
    end

endmodule

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Multi-channel push-button front end: NUM_BUTTONS independent
// debounce_channel instances sharing one clock and reset.
// Ports:
//   clock        in  system clock
//   reset_n      in  synchronous active-low reset
//   button_n     in  [NUM_BUTTONS] raw inverting buttons (0 = pressed)
//   button_state out [NUM_BUTTONS] debounced level, 1 = pressed
//   button_event out [NUM_BUTTONS] one-cycle accepted-transition pulses
//   button_long  out [NUM_BUTTONS] one-cycle long-press pulses
// -----------------------------------------------------------------------------
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS       = 1,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter event_mode_t EVENT_MODE        = EVENT_PRESS,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] button_n,
    output logic [NUM_BUTTONS-1:0] button_state,
    output logic [NUM_BUTTONS-1:0] button_event,
    output logic [NUM_BUTTONS-1:0] button_long
);

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES      (SYNC_STAGES),
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .EVENT_MODE       (EVENT_MODE),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_ch (
            .clock       (clock),
            .reset_n     (reset_n),
            .button_n    (button_n[g]),
            .button_state(button_state[g]),
            .button_event(button_event[g]),
            .button_long (button_long[g])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;
    import button_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:0] button_n;
    logic [1:0] st_p, ev_p, lg_p;
    logic [1:0] st_b, ev_b, lg_b;

    int checks = 0;
    int errors = 0;

    // per-window activity counters (channel 0 unless noted)
    int cyc, n_evp0, n_evb0, n_st0, n_lgp0, n_lgb0, n_ch1, st_rise_cyc, lg_cyc;
    logic prev_st0;

    always #5 clock = ~clock;

    button_debounce #(
        .NUM_BUTTONS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .EVENT_MODE(EVENT_PRESS), .LONG_PRESS_CYCLES(10)
    ) dut_p (
        .clock(clock), .reset_n(reset_n), .button_n(button_n),
        .button_state(st_p), .button_event(ev_p), .button_long(lg_p)
    );

    button_debounce #(
        .NUM_BUTTONS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .EVENT_MODE(EVENT_BOTH), .LONG_PRESS_CYCLES(10)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .button_n(button_n),
        .button_state(st_b), .button_event(ev_b), .button_long(lg_b)
    );

    typedef struct {
        logic [1:0] bn;
        logic       rn;
        logic [1:0] st;
        logic [1:0] evp;
        logic [1:0] evb;
        logic [1:0] lg;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] bn, input logic rn, input logic [1:0] st,
                       input logic [1:0] evp, input logic [1:0] evb, input logic [1:0] lg);
        vec_t v;
        v.bn = bn; v.rn = rn; v.st = st; v.evp = evp; v.evb = evb; v.lg = lg;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        cyc = 0; n_evp0 = 0; n_evb0 = 0; n_st0 = 0; n_lgp0 = 0; n_lgb0 = 0; n_ch1 = 0;
        st_rise_cyc = -1; lg_cyc = -1; prev_st0 = st_p[0];
    endtask

    // apply bn for n cycles, accumulating activity seen after each edge
    task automatic run(input logic [1:0] bn, input int n);
        for (int i = 0; i < n; i++) begin
            button_n = bn;
            tick();
            cyc++;
            if (ev_p[0]) n_evp0++;
            if (ev_b[0]) n_evb0++;
            if (st_p[0]) n_st0++;
            if (lg_p[0]) n_lgp0++;
            if (lg_b[0]) n_lgb0++;
            if (st_p[1] | ev_p[1] | ev_b[1] | lg_p[1] | lg_b[1] | st_b[1]) n_ch1++;
            if (st_p[0] && !prev_st0 && st_rise_cyc < 0) st_rise_cyc = cyc;
            if (lg_p[0] && lg_cyc < 0) lg_cyc = cyc;
            prev_st0 = st_p[0];
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        button_n = 2'b11;

        // clean press then clean release on channel 0, one row per clock edge
        add(2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        add(2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 6; i++) add(2'b10, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        add(2'b10, 1'b1, 2'b01, 2'b01, 2'b01, 2'b00);
        add(2'b10, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 6; i++) add(2'b11, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00);
        add(2'b11, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00);
        add(2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            button_n = vecs[i].bn;
            reset_n  = vecs[i].rn;
            tick();
            chk($sformatf("vec%0d state_p", i), st_p, vecs[i].st);
            chk($sformatf("vec%0d state_b", i), st_b, vecs[i].st);
            chk($sformatf("vec%0d event_p", i), ev_p, vecs[i].evp);
            chk($sformatf("vec%0d event_b", i), ev_b, vecs[i].evb);
            chk($sformatf("vec%0d long_p", i), lg_p, vecs[i].lg);
            chk($sformatf("vec%0d long_b", i), lg_b, vecs[i].lg);
        end

        // glitch of 4 cycles is rejected
        clr();
        run(2'b10, 4);
        run(2'b11, 12);
        chk_int("glitch4_state_cycles", n_st0, 0);
        chk_int("glitch4_events_b", n_evb0, 0);

        // glitch of 5 cycles is accepted as a short press then released
        clr();
        run(2'b10, 5);
        run(2'b11, 16);
        chk_int("glitch5_events_p", n_evp0, 1);
        chk_int("glitch5_events_b", n_evb0, 2);
        chk_int("glitch5_state_cycles", n_st0, 5);

        // long press: hold 25 cycles, single pulse 10 edges after state rise
        clr();
        run(2'b10, 25);
        chk_int("long_state_rise", st_rise_cyc, 7);
        chk_int("long_pulse_cycle", lg_cyc, 17);
        chk_int("long_pulses_p", n_lgp0, 1);
        chk_int("long_pulses_b", n_lgb0, 1);
        run(2'b11, 12);
        chk_int("long_after_release_p", n_lgp0, 1);
        chk_int("long_ch1_quiet", n_ch1, 0);
        chk("long_final_state", st_p, 2'b00);

        // press, then a 2-cycle release bounce must not change state or pulse
        clr();
        run(2'b10, 7);
        chk_int("bounce_press_event_b", n_evb0, 1);
        chk("bounce_pressed_state", st_b, 2'b01);
        clr();
        run(2'b11, 2);
        run(2'b10, 10);
        chk_int("bounce_events_b", n_evb0, 0);
        chk_int("bounce_events_p", n_evp0, 0);
        chk_int("bounce_state_cycles", n_st0, 12);
        // clean release: state drops after release edge 6
        run(2'b11, 6);
        chk("release_state_r5", st_b, 2'b01);
        run(2'b11, 1);
        chk("release_state_r6", st_b, 2'b00);
        chk("release_event_b", ev_b, 2'b01);
        chk("release_event_p", ev_p, 2'b00);
        run(2'b11, 3);
        chk("release_event_b_gone", ev_b, 2'b00);

        // reset mid-press, button still held afterwards
        run(2'b10, 10);
        chk("pre_reset_state", st_p, 2'b01);
        reset_n = 1'b0;
        run(2'b10, 1);
        chk("reset_state_p", st_p, 2'b00);
        chk("reset_state_b", st_b, 2'b00);
        chk("reset_event_p", ev_p, 2'b00);
        chk("reset_event_b", ev_b, 2'b00);
        chk("reset_long_p", lg_p, 2'b00);
        chk("reset_long_b", lg_b, 2'b00);
        reset_n = 1'b1;
        clr();
        run(2'b10, 10);
        chk_int("rearm_state_rise", st_rise_cyc, 7);
        chk_int("rearm_events_p", n_evp0, 1);
        chk_int("rearm_events_b", n_evb0, 1);
        run(2'b11, 10);

        // simultaneous press on both channels
        run(2'b00, 6);
        chk("simul_before_p", ev_p, 2'b00);
        run(2'b00, 1);
        chk("simul_event_p", ev_p, 2'b11);
        chk("simul_event_b", ev_b, 2'b11);
        chk("simul_state", st_p, 2'b11);
        run(2'b00, 1);
        chk("simul_event_gone_p", ev_p, 2'b00);
        chk("simul_event_gone_b", ev_b, 2'b00);
        run(2'b11, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
